// File: rtl/dmux1_8e_deser.sv
// Serial-to-8-bit deserializer for the enabled 8:1 mux stream. The frame is presented 1 cycle after its last bit is sampled.
// No backpressure: bits are captured only when E=1. Define DMUX_SEL_OUT_EN to expose the slot counter on S0..S2.
module dmux1_8e_deser #(
    parameter logic [7:0] INIT_O = 8'h00
) (
    input  logic C,
    input  logic R,
    input  logic D,
    input  logic E,
    input  logic SYNC,
    output logic O0,
    output logic O1,
    output logic O2,
    output logic O3,
    output logic O4,
    output logic O5,
    output logic O6,
    output logic O7,
    output logic VLD,
`ifdef DMUX_SEL_OUT_EN
    output logic S0,
    output logic S1,
    output logic S2,
`endif
    output logic ERR
);

    logic [2:0] cnt;
    logic [2:0] slot;
    logic [7:0] shreg;
    logic [7:0] frame_q;
    logic       last_slot;

    // SYNC re-anchors the current bit to slot 0, even mid-frame.
    always_comb begin
        slot      = SYNC ? 3'd0 : cnt;
        last_slot = E && (slot == 3'd7);
    end

    always_ff @(posedge C) begin
        if (R) begin
            cnt     <= 3'd0;
            shreg   <= 8'h00;
            frame_q <= INIT_O;
            VLD     <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            VLD <= last_slot;
            ERR <= SYNC && (cnt != 3'd0);
            if (E) begin
                shreg[slot] <= D;
                cnt         <= slot + 3'd1;
            end else if (SYNC) begin
                cnt <= 3'd0;
            end
            // The bit arriving in slot 7 bypasses the buffer.
            if (last_slot) begin
                frame_q <= {D, shreg[6:0]};
            end
        end
    end

    assign {O7, O6, O5, O4, O3, O2, O1, O0} = frame_q;

`ifdef DMUX_SEL_OUT_EN
    assign S0 = cnt[0];
    assign S1 = cnt[1];
    assign S2 = cnt[2];
`endif

endmodule

// File: tb/tb_dmux1_8e_deser.sv
// Randomized and directed bench for dmux1_8e_deser. It uses a bit-list reference model and a cycle-tagged scoreboard.
module tb_dmux1_8e_deser;
    localparam logic [7:0] INIT = 8'h3C;

    logic C = 1'b0;
    logic R = 1'b1;
    logic D = 1'b0;
    logic E = 1'b0;
    logic SYNC = 1'b0;
    logic O0, O1, O2, O3, O4, O5, O6, O7, VLD, ERR;
`ifdef DMUX_SEL_OUT_EN
    logic S0, S1, S2;
`endif

    dmux1_8e_deser #(.INIT_O(INIT)) dut (
        .C(C), .R(R), .D(D), .E(E), .SYNC(SYNC),
        .O0(O0), .O1(O1), .O2(O2), .O3(O3), .O4(O4), .O5(O5), .O6(O6), .O7(O7),
        .VLD(VLD),
`ifdef DMUX_SEL_OUT_EN
        .S0(S0), .S1(S1), .S2(S2),
`endif
        .ERR(ERR)
    );

    always #5 C = ~C;

    int cyc = 0;
    always @(posedge C) cyc = cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] val;
    } ev_t;

    ev_t  vq[$];
    int   eq[$];
    bit   bits[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // The model keeps the bits of the frame in progress. The counter equals the list length.
    task automatic step(input bit r, input bit d, input bit e, input bit s);
        logic [7:0] v;
        ev_t ev;
        R = r; D = d; E = e; SYNC = s;
        if (r) begin
            bits.delete();
        end else begin
            if (s) begin
                if (bits.size() != 0) eq.push_back(cyc + 1);
                bits.delete();
            end
            if (e) begin
                bits.push_back(d);
                if (bits.size() == 8) begin
                    v = 8'h00;
                    for (int i = 0; i < 8; i++) v[i] = bits[i];
                    ev.at = cyc + 1;
                    ev.val = v;
                    vq.push_back(ev);
                    bits.delete();
                end
            end
        end
        @(posedge C);
        #1;
    endtask

    task automatic send(input logic [7:0] v, input bit sync_first);
        for (int i = 0; i < 8; i++) step(1'b0, v[i], 1'b1, sync_first && (i == 0));
    endtask

    // Monitor: at each falling edge it compares outputs against the scoreboard.
    logic [7:0] last_o;
    bit         rst_prev = 1'b1;
    bit         exp_v, exp_e;
    always @(negedge C) begin
        if (rst_prev) last_o = INIT;
        exp_v = (vq.size() > 0) && (vq[0].at == cyc);
        if (exp_v) begin
            last_o = vq[0].val;
            void'(vq.pop_front());
        end
        exp_e = (eq.size() > 0) && (eq[0] == cyc);
        if (exp_e) void'(eq.pop_front());
        chk("vld", {7'd0, VLD}, {7'd0, exp_v});
        chk("err", {7'd0, ERR}, {7'd0, exp_e});
        chk("o", {O7, O6, O5, O4, O3, O2, O1, O0}, last_o);
`ifdef DMUX_SEL_OUT_EN
        chk("sel", {5'd0, S2, S1, S0}, 8'(bits.size()));
`endif
        rst_prev = R;
    end

    initial begin
        // Reset for two cycles.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // Single frame.
        send(8'hA5, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // E gap after four bits.
        for (int i = 0; i < 4; i++) step(1'b0, 8'hA5 >> i, 1'b1, i == 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 4; i < 8; i++) step(1'b0, 8'hA5 >> i, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // Back-to-back frames with E held high.
        send(8'hFF, 1'b1);
        send(8'h00, 1'b0);
        // SYNC after three bits, then SYNC with E=0 mid-frame.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        send(8'h5A, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        send(8'h3A, 1'b0);
        // Reset after five bits, then a full frame.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, i == 0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send(8'h81, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 64) == 0, 1'($urandom), ($urandom % 4) != 0, ($urandom % 16) == 0);
        end
        for (int n = 0; n < 3; n++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("vq_drained", 8'(vq.size()), 8'd0);
        chk("eq_drained", 8'(eq.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
